array_collect: RTL and testbench
================================

Name: array_collect

Overview:
- Stream-to-array deserializer: accepts one CELL_WIDTH cell per handshake, with a last marker on the final cell.
- Assembles the cells into a flat ARRAY_HEIGHT x ARRAY_WIDTH array and presents it as a single parallel word with valid/ready.
- Inverse of the array-to-stream dump path; used to rebuild arrays arriving over serial links before parallel processing.
- Single frame buffer; detects and recovers from short and long frames.

Parameters:
- ARRAY_HEIGHT, 2, number of array rows
- ARRAY_WIDTH, 2, number of array columns
- CELL_WIDTH, 8, bits per cell

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_data  in  CELL_WIDTH  incoming cell
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a cell
- in_last  in  1  current cell is final cell of frame
- out_data  out  ARRAY_HEIGHT*ARRAY_WIDTH*CELL_WIDTH  assembled array; cell i at bits [i*CELL_WIDTH +: CELL_WIDTH]
- out_valid  out  1  out_data holds complete frame
- out_ready  in  1  downstream accepts out_data
- out_error  out  1  frame length mismatch; meaningful only while out_valid=1

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- ARRAY_SIZE = ARRAY_HEIGHT*ARRAY_WIDTH. Index counter width = $clog2(ARRAY_SIZE+1).
- Accept = in_valid && in_ready. Send = out_valid && out_ready.
- Reset values: state RECEIVING, index 0, buffer 0, error 0. Outputs: in_ready=1, out_valid=0, out_error=0, out_data=0.
- out_data is driven directly from the buffer. It shows partial contents while receiving; consumers ignore it unless out_valid=1.
- States:
  - RECEIVING: in_ready=1, out_valid=0.
    - On accept, write in_data to buffer slot [index].
    - If in_last=1: go to SENDING. Set error=1 if index != ARRAY_SIZE-1 (short frame); unwritten slots stay 0.
    - Else if index == ARRAY_SIZE-1 (full without last): go to DRAINING with error=1.
    - Else index increments.
  - DRAINING: in_ready=1, out_valid=0.
    - Accepted cells are discarded.
    - Accepting a cell with in_last=1 moves to SENDING; error stays 1.
  - SENDING: in_ready=0, out_valid=1, out_error=error.
    - On send: clear buffer to 0, index to 0, error to 0, and go to RECEIVING.
- Latency:
  - Last cell accepted on cycle N gives out_valid=1 on cycle N+1.
  - out_data and out_error are stable while out_valid=1 and out_ready=0.
- Throughput:
  - One cell per cycle while receiving.
  - After a send, in_ready rises the following cycle. There is no overlap of the next frame with a pending output, so at least one bubble per frame.
- Single-cell frame: in_last on the first cell gives cell 0 loaded, the rest 0, and error=1 unless ARRAY_SIZE=1.
- Edge cases:
  - ARRAY_SIZE=1: the first cell is always full. in_last=1 goes to SENDING with no error; in_last=0 goes to DRAINING with error.
  - Reset mid-frame or mid-send: returns to reset values on the next edge. A partial frame is dropped and no out_valid is produced for it.
  - in_valid/in_last while in SENDING: ignored (in_ready=0); the upstream holds them.
- Index never exceeds ARRAY_SIZE-1; no wrap.

Test Plan (2x2, CELL_WIDTH=8):
- Normal frame: cells 0x11,0x22,0x33,0x44 on consecutive cycles, last on 0x44, out_ready=1 -> one cycle later out_valid=1, out_data=0x44332211, out_error=0; next cycle in_ready=1.
- Backpressure: same frame with out_ready=0 for 5 cycles -> out_valid and out_data=0x44332211 held constant, in_ready=0 throughout; after out_ready=1, one send, then in_ready=1.
- Short frame: cells 0xAA, 0xBB with last on 0xBB -> out_data=0x0000BBAA, out_error=1. A following normal frame 1,2,3,4 -> out_data=0x04030201, out_error=0, confirming the buffer is cleared.
- Long frame: six cells 1..6, last on 6 -> in_ready stays 1 through cells 5 and 6; out_valid rises after cell 6; out_data=0x04030201, out_error=1.
- Gapped input: in_valid toggled 1/0 across four cells -> only handshaken cells are stored; result is correct.
- Reset mid-frame: two cells accepted, reset pulsed for one cycle, then a full frame 9,8,7,6 -> out_data=0x06070809, out_error=0, and no spurious out_valid before it.

Source files
------------

// File: rtl/array_collect.sv
// Stream-to-array deserializer: collects CELL_WIDTH cells into one flat
// ARRAY_HEIGHT x ARRAY_WIDTH word, flagging frames whose length is wrong.
module array_collect #(
  parameter int ARRAY_HEIGHT = 2,
  parameter int ARRAY_WIDTH  = 2,
  parameter int CELL_WIDTH   = 8
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic [CELL_WIDTH-1:0]                       in_data,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic                                        in_last,
  output logic [ARRAY_HEIGHT*ARRAY_WIDTH*CELL_WIDTH-1:0] out_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic                                        out_error
);

  localparam int ARRAY_SIZE = ARRAY_HEIGHT * ARRAY_WIDTH;
  localparam int IDX_W      = $clog2(ARRAY_SIZE + 1);
  localparam int SLOT_W     = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_SIZE - 1);

  typedef enum logic [1:0] {
    RECEIVING,
    DRAINING,
    SENDING
  } state_t;

  state_t                                  state;
  logic [IDX_W-1:0]                        index;
  logic [ARRAY_SIZE-1:0][CELL_WIDTH-1:0]   buffer;
  logic                                    accept;
  logic [SLOT_W-1:0]                       slot;

  assign accept   = in_valid && in_ready;
  assign slot     = index[SLOT_W-1:0];
  assign out_data = buffer;

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RECEIVING;
      index     <= '0;
      // NOTE: the buffer is deliberately reset (and cleared after each send)
      // because unwritten slots of a short frame must read back as zero.
      buffer    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_error <= 1'b0;
    end else begin
      case (state)
        RECEIVING: begin
          if (accept) begin
            buffer[slot] <= in_data;
            if (in_last) begin
              state     <= SENDING;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_error <= (index != LAST_IDX);
            end else if (index == LAST_IDX) begin
              // Array full but the frame keeps going: discard the tail.
              state <= DRAINING;
            end else begin
              index <= index + 1'b1;
            end
          end
        end

        DRAINING: begin
          if (accept && in_last) begin
            state     <= SENDING;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_error <= 1'b1;
          end
        end

        SENDING: begin
          if (out_ready) begin
            state     <= RECEIVING;
            index     <= '0;
            buffer    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_error <= 1'b0;
          end
        end

        default: begin
          state     <= RECEIVING;
          index     <= '0;
          buffer    <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_error <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_array_collect.sv
// Directed bench for array_collect (2x2, 8-bit cells): normal, backpressure,
// short, long, gapped, single-cell and reset-mid-frame scenarios.
module tb_array_collect;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_error;

  int n_checks = 0;
  int n_fail   = 0;

  array_collect #(
    .ARRAY_HEIGHT(2),
    .ARRAY_WIDTH (2),
    .CELL_WIDTH  (8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_error(out_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one cell for a single cycle; it is accepted on that edge.
  task automatic send_cell(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'hEE;
  endtask

  task automatic expect_frame(input string tag, input logic [31:0] d, input logic e);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".data"},  out_data, d);
    check({tag, ".error"}, 32'(out_error), 32'(e));
    check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
  endtask

  // One edge with out_ready=1 consumes the frame and reopens the input.
  task automatic expect_consumed(input string tag);
    tick();
    check({tag, ".valid_low"}, 32'(out_valid), 32'd0);
    check({tag, ".in_ready"},  32'(in_ready), 32'd1);
    check({tag, ".cleared"},   out_data, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset.in_ready",  32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_error", 32'(out_error), 32'd0);
    check("reset.out_data",  out_data, 32'd0);

    // Normal frame
    send_cell(8'h11, 1'b0);
    send_cell(8'h22, 1'b0);
    send_cell(8'h33, 1'b0);
    check("normal.no_early_valid", 32'(out_valid), 32'd0);
    send_cell(8'h44, 1'b1);
    expect_frame("normal", 32'h44332211, 1'b0);
    expect_consumed("normal");

    // Backpressure: output held for 5 cycles while upstream pushes a cell
    out_ready = 1'b0;
    send_cell(8'h11, 1'b0);
    send_cell(8'h22, 1'b0);
    send_cell(8'h33, 1'b0);
    send_cell(8'h44, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h99;
    in_last  = 1'b1;
    expect_frame("bp0", 32'h44332211, 1'b0);
    for (int i = 1; i < 5; i++) begin
      tick();
      expect_frame($sformatf("bp%0d", i), 32'h44332211, 1'b0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    expect_consumed("bp");

    // Short frame, then a normal frame proving the buffer was cleared
    send_cell(8'hAA, 1'b0);
    send_cell(8'hBB, 1'b1);
    expect_frame("short", 32'h0000BBAA, 1'b1);
    expect_consumed("short");
    send_cell(8'h01, 1'b0);
    send_cell(8'h02, 1'b0);
    send_cell(8'h03, 1'b0);
    send_cell(8'h04, 1'b1);
    expect_frame("after_short", 32'h04030201, 1'b0);
    expect_consumed("after_short");

    // Long frame: cells 5 and 6 are drained
    send_cell(8'h01, 1'b0);
    send_cell(8'h02, 1'b0);
    send_cell(8'h03, 1'b0);
    send_cell(8'h04, 1'b0);
    check("long.drain_ready4", 32'(in_ready), 32'd1);
    send_cell(8'h05, 1'b0);
    check("long.drain_ready5", 32'(in_ready), 32'd1);
    check("long.drain_novalid", 32'(out_valid), 32'd0);
    send_cell(8'h06, 1'b1);
    expect_frame("long", 32'h04030201, 1'b1);
    expect_consumed("long");

    // Gapped input: idle cycles carry junk data with in_valid low
    send_cell(8'h5A, 1'b0);
    in_data = 8'hC3; in_last = 1'b1; tick(); in_last = 1'b0;
    send_cell(8'h6B, 1'b0);
    in_data = 8'hC4; tick();
    send_cell(8'h7C, 1'b0);
    in_data = 8'hC5; tick();
    check("gap.no_early_valid", 32'(out_valid), 32'd0);
    send_cell(8'h8D, 1'b1);
    expect_frame("gap", 32'h8D7C6B5A, 1'b0);
    expect_consumed("gap");

    // Single-cell frame
    send_cell(8'h77, 1'b1);
    expect_frame("single", 32'h00000077, 1'b1);
    expect_consumed("single");

    // Reset mid-frame drops the partial frame
    send_cell(8'hF1, 1'b0);
    send_cell(8'hF2, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst.in_ready",  32'(in_ready), 32'd1);
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.out_data",  out_data, 32'd0);
    send_cell(8'h09, 1'b0);
    check("midrst.v1", 32'(out_valid), 32'd0);
    send_cell(8'h08, 1'b0);
    check("midrst.v2", 32'(out_valid), 32'd0);
    send_cell(8'h07, 1'b0);
    check("midrst.v3", 32'(out_valid), 32'd0);
    send_cell(8'h06, 1'b1);
    expect_frame("midrst", 32'h06070809, 1'b0);
    expect_consumed("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
